uart_sram_ctrl: RTL

UART_SRAM_CTRL -- requirements
Module: uart_sram_ctrl

---
 rtl/uart_sram_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/uart_sram_ctrl.sv
// uart_sram_ctrl
//   Bridges a simple level-request access port onto an asynchronous SRAM and
//   a byte-wide UART that share one 16-bit data bus. One address is the UART
//   data register and one is the UART status register. Every other address
//   goes to the SRAM.
//
// Ports
//   Clk0, Rst           clock; asynchronous active-low reset
//   req, we, addr,      access request, captured only while idle
//   wdata
//   rdata, ack, busy    read result, one-cycle completion pulse, busy flag
//   Ram1_EN/OE/WE       SRAM strobes, active-low
//   Ram1_address        {2'b00, latched addr}
//   Ram1_data           shared SRAM/UART data bus (tristate)
//   rdn, wrn            UART read/write strobes, active-low
//   data_ready, tbre,   UART status inputs, synchronous to Clk0
//   tsre
module uart_sram_ctrl #(
    parameter int unsigned SRAM_WAIT      = 1,
    parameter logic [15:0] UART_DATA_ADDR = 16'hBF00,
    parameter logic [15:0] UART_STAT_ADDR = 16'hBF01
) (
    input  logic        Clk0,
    input  logic        Rst,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        ack,
    output logic        busy,
    output logic        Ram1_EN,
    output logic        Ram1_OE,
    output logic        Ram1_WE,
    output logic [17:0] Ram1_address,
    inout  wire  [15:0] Ram1_data,
    output logic        rdn,
    output logic        wrn,
    input  logic        data_ready,
    input  logic        tbre,
    input  logic        tsre
);

    // A status access completes on the accepting edge, so the status
    // "state" collapses into the IDLE -> DONE transition.
    typedef enum logic [3:0] {
        IDLE, SR, SW_SETUP, SW_PULSE, SW_HOLD,
        UR_WAIT, UR_PULSE, UW_WAIT, UW_SETUP, UW_PULSE, DONE
    } state_t;

    localparam logic [2:0] WAIT_LAST = 3'(SRAM_WAIT);

    state_t      state, nextState;
    logic [2:0]  cnt;      // cycles spent in the current state
    logic [15:0] addrQ;
    logic [15:0] wdataQ;
    logic        busOe;

    // State register plus datapath captures
    always_ff @(posedge Clk0 or negedge Rst) begin
        if (!Rst) begin
            state  <= IDLE;
            cnt    <= '0;
            addrQ  <= '0;
            wdataQ <= '0;
            rdata  <= '0;
        end else begin
            state <= nextState;
            cnt   <= (nextState != state) ? 3'd0 : cnt + 3'd1;
            if (state == IDLE && req) begin
                addrQ  <= addr;
                wdataQ <= wdata;
                if (addr == UART_STAT_ADDR && !we)
                    rdata <= {14'b0, data_ready, tbre & tsre};
            end
            if (state == SR && nextState == DONE)
                rdata <= Ram1_data;
            if (state == UR_PULSE && nextState == DONE)
                rdata <= {8'h00, Ram1_data[7:0]};
        end
    end

    // Next-state logic
    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (req) begin
                if (addr == UART_STAT_ADDR)      nextState = DONE;
                else if (addr == UART_DATA_ADDR) nextState = we ? UW_WAIT : UR_WAIT;
                else                             nextState = we ? SW_SETUP : SR;
            end
            SR:       if (cnt == WAIT_LAST) nextState = DONE;
            SW_SETUP: nextState = SW_PULSE;
            SW_PULSE: if (cnt == WAIT_LAST) nextState = SW_HOLD;
            SW_HOLD:  nextState = DONE;
            UR_WAIT:  if (data_ready) nextState = UR_PULSE;
            UR_PULSE: if (cnt == 3'd1) nextState = DONE;
            UW_WAIT:  if (tbre && tsre) nextState = UW_SETUP;
            UW_SETUP: nextState = UW_PULSE;
            UW_PULSE: if (cnt == 3'd1) nextState = DONE;
            DONE:     nextState = IDLE;
            default:  nextState = IDLE;
        endcase
    end

    // Outputs decoded purely from state so reset deasserts them at once
    always_comb begin
        busy    = (state != IDLE);
        ack     = (state == DONE);
        Ram1_EN = 1'b1;
        Ram1_OE = 1'b1;
        Ram1_WE = 1'b1;
        rdn     = 1'b1;
        wrn     = 1'b1;
        busOe   = 1'b0;
        case (state)
            SR: begin
                Ram1_EN = 1'b0;
                Ram1_OE = 1'b0;
            end
            SW_SETUP, SW_HOLD: begin
                Ram1_EN = 1'b0;
                busOe   = 1'b1;
            end
            SW_PULSE: begin
                Ram1_EN = 1'b0;
                Ram1_WE = 1'b0;
                busOe   = 1'b1;
            end
            UR_PULSE: rdn = 1'b0;
            UW_SETUP: busOe = 1'b1;
            UW_PULSE: begin
                wrn   = 1'b0;
                busOe = 1'b1;
            end
            default: ;
        endcase
    end

    assign Ram1_address = {2'b00, addrQ};
    assign Ram1_data    = busOe ? wdataQ : 16'hzzzz;

endmodule
